// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with a single-cycle fast path for the divide special cases.
module riscv_muldiv #(
  parameter int MP_DATA_WIDTH = 32
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic                     istart,
  input  logic                     iflush,
  input  logic [2:0]               ifunct3,
  input  logic [MP_DATA_WIDTH-1:0] ia,
  input  logic [MP_DATA_WIDTH-1:0] ib,
  output logic                     obusy,
  output logic                     ovalid,
  output logic [MP_DATA_WIDTH-1:0] oresult
);

  localparam int W  = MP_DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic [2*W-1:0]  acc;     // {high, low} product, or {remainder, quotient}
  logic [W-1:0]    breg;    // multiplicand / divisor magnitude
  logic            neg_q;   // negate product or quotient at the end
  logic            neg_r;   // negate remainder at the end

  // Operand decode at start
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0]    mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic [W-1:0]    special_res;

  // One iteration and the final sign correction
  logic [W:0]      mul_sum, rem_sh, div_diff;
  logic [2*W-1:0]  step, prod;
  logic [W-1:0]    quo, rem, final_res;

  // NOTE: every signal written in always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (ifunct3)
      3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
    a_neg = a_signed & ia[W-1];
    b_neg = b_signed & ib[W-1];
    mag_a = a_neg ? -ia : ia;
    mag_b = b_neg ? -ib : ib;

    div_zero = ifunct3[2] & (ib == '0);
    div_ovf  = ifunct3[2] & ~ifunct3[0] & (ia == MOST_NEG) & (ib == '1);
    special  = div_zero | div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = ifunct3[1] ? ia : '1;
    else if (div_ovf)
      special_res = ifunct3[1] ? '0 : ia;
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, breg} : '0);
    rem_sh   = acc[2*W-1:W-1];
    div_diff = rem_sh - {1'b0, breg};
    if (op[2]) begin
      // Restoring step: keep the trial difference only when it did not go negative.
      if (div_diff[W])
        step = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
      else
        step = {div_diff[W-1:0], acc[W-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc[W-1:1]};
    end

    prod = neg_q ? -step : step;
    quo  = neg_q ? -step[W-1:0] : step[W-1:0];
    rem  = neg_r ? -step[2*W-1:W] : step[2*W-1:W];

    case (op)
      3'b000:                 final_res = prod[W-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*W-1:W];
      3'b100, 3'b101:         final_res = quo;
      default:                final_res = rem;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      acc     <= '0;
      breg    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      obusy   <= 1'b0;
      ovalid  <= 1'b0;
      oresult <= '0;
    end else begin
      ovalid <= 1'b0;
      case (state)
        IDLE: begin
          if (istart && !iflush) begin
            op    <= ifunct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            acc   <= {{W{1'b0}}, mag_a};
            breg  <= mag_b;
            cnt   <= CW'(W);
            obusy <= 1'b1;
            if (special) begin
              state   <= DONE;
              ovalid  <= 1'b1;
              oresult <= special_res;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (iflush) begin
            state <= IDLE;
            obusy <= 1'b0;
          end else begin
            acc <= step;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              state   <= DONE;
              ovalid  <= 1'b1;
              oresult <= final_res;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          obusy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          obusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv: directed RV32M cases, latency, flush, reset
// and random back-to-back operations checked against a behavioural model.
module tb_riscv_muldiv;

  logic        iclk = 1'b0;
  logic        irst_n = 1'b0;
  logic        istart = 1'b0;
  logic        iflush = 1'b0;
  logic [2:0]  ifunct3 = '0;
  logic [31:0] ia = '0;
  logic [31:0] ib = '0;
  logic        obusy;
  logic        ovalid;
  logic [31:0] oresult;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  riscv_muldiv #(.MP_DATA_WIDTH(32)) dut (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .istart  (istart),
    .iflush  (iflush),
    .ifunct3 (ifunct3),
    .ia      (ia),
    .ib      (ib),
    .obusy   (obusy),
    .ovalid  (ovalid),
    .oresult (oresult)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    p  = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == MIN_INT && b == 32'hFFFF_FFFF));
  endfunction

  // Scoreboard consumer: every ovalid must match the oldest outstanding expectation.
  always @(negedge iclk) begin
    if (irst_n && ovalid) begin
      if (exp_q.size() == 0) check("unexpected_valid", {31'b0, ovalid}, 32'h0);
      else check("result", oresult, exp_q.pop_front());
    end
  end

  // Drive one operation and check busy/latency/hold behaviour around it.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input bit noise);
    int n;
    int lat;
    lat = is_special(f3, a, b) ? 1 : 33;
    @(negedge iclk);
    istart = 1'b1; ifunct3 = f3; ia = a; ib = b;
    exp_q.push_back(expv);
    @(posedge iclk);
    @(negedge iclk);
    istart = 1'b0; ifunct3 = 3'($urandom); ia = $urandom; ib = $urandom;
    n = 1;
    check("busy_cycle1", {31'b0, obusy}, 32'h1);
    while (!ovalid && n < 100) begin
      istart = noise && n >= 3 && n <= 6;
      @(negedge iclk);
      n++;
    end
    istart = 1'b0;
    check("latency", 32'(n), 32'(lat));
    check("busy_at_valid", {31'b0, obusy}, 32'h1);
    @(negedge iclk);
    check("idle_after_done", {31'b0, obusy}, 32'h0);
    check("result_hold", oresult, expv);
    last_res = expv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;

    #12;
    check("reset_busy", {31'b0, obusy}, 32'h0);
    check("reset_valid", {31'b0, ovalid}, 32'h0);
    check("reset_result", oresult, 32'h0);
    @(negedge iclk);
    irst_n = 1'b1;

    // Basic multiply plus the high-half variants
    run_op(3'd0, 32'd7, 32'd6, 32'd42, 1'b0);
    run_op(3'd1, MIN_INT, MIN_INT, 32'h4000_0000, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0);

    // Divide and remainder, signed and unsigned
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0);

    // Fast-path special cases
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op(3'd4, MIN_INT, 32'hFFFF_FFFF, MIN_INT, 1'b0);
    run_op(3'd6, MIN_INT, 32'hFFFF_FFFF, 32'h0, 1'b0);

    // Flush at cycle 10 of a divide: nothing is pushed, so any ovalid is caught.
    @(negedge iclk);
    istart = 1'b1; ifunct3 = 3'd4; ia = 32'd1000; ib = 32'd3;
    @(posedge iclk);
    @(negedge iclk);
    istart = 1'b0;
    repeat (9) @(negedge iclk);
    iflush = 1'b1;
    @(negedge iclk);
    iflush = 1'b0;
    check("flush_idle", {31'b0, obusy}, 32'h0);
    check("flush_result_kept", oresult, last_res);
    run_op(3'd0, 32'd123, 32'hFFFF_FFFE, 32'hFFFF_FF0A, 1'b0);

    // Asynchronous reset in the middle of a multiply
    @(negedge iclk);
    istart = 1'b1; ifunct3 = 3'd0; ia = 32'd9; ib = 32'd9;
    @(posedge iclk);
    @(negedge iclk);
    istart = 1'b0;
    repeat (4) @(negedge iclk);
    irst_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, obusy}, 32'h0);
    check("rst_valid", {31'b0, ovalid}, 32'h0);
    check("rst_result", oresult, 32'h0);
    @(negedge iclk);
    irst_n = 1'b1;
    last_res = '0;

    // istart held high during busy must not start a second operation
    run_op(3'd5, 32'd12345, 32'd17, 32'd726, 1'b1);
    run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, model(3'd1, 32'hDEAD_BEEF, 32'h1234_5678), 1'b1);

    // Random back-to-back operations, biased towards boundary operands
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = MIN_INT; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = MIN_INT;
        default: ;
      endcase
      run_op(f3, a, b, model(f3, a, b), (i % 5 == 0) && !is_special(f3, a, b));
    end

    repeat (3) @(negedge iclk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
